// File: rtl/fpu_arith_pkg.sv
// Shared definitions for the FP80 arithmetic-unit sequencer: op codes,
// exception flag / condition-code bit indices and the FSM state encoding.
package fpu_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD          = 4'd0;
  localparam logic [3:0] OP_SUB          = 4'd1;
  localparam logic [3:0] OP_MUL          = 4'd2;
  localparam logic [3:0] OP_DIV          = 4'd3;
  localparam logic [3:0] OP_SQRT         = 4'd4;
  localparam logic [3:0] OP_ROUND        = 4'd5;
  localparam logic [3:0] OP_FP_TO_INT16  = 4'd6;
  localparam logic [3:0] OP_FP_TO_INT32  = 4'd7;
  localparam logic [3:0] OP_INT16_TO_FP  = 4'd8;
  localparam logic [3:0] OP_INT32_TO_FP  = 4'd9;
  localparam logic [3:0] OP_FP_TO_FP32   = 4'd10;
  localparam logic [3:0] OP_FP_TO_FP64   = 4'd11;

  // flags = {invalid, denormal, zero_divide, overflow, underflow, inexact}
  localparam int FLAG_INVALID     = 5;
  localparam int FLAG_DENORMAL    = 4;
  localparam int FLAG_ZERO_DIVIDE = 3;
  localparam int FLAG_OVERFLOW    = 2;
  localparam int FLAG_UNDERFLOW   = 1;
  localparam int FLAG_INEXACT     = 0;

  // cc = {less, equal, greater, unordered}
  localparam int CC_LESS      = 3;
  localparam int CC_EQUAL     = 2;
  localparam int CC_GREATER   = 1;
  localparam int CC_UNORDERED = 0;

  localparam logic [5:0] FLAGS_INVALID_ONLY = 6'b100000;

  function automatic logic op_is_valid(input logic [3:0] op);
    return op <= OP_FP_TO_FP64;
  endfunction

endpackage

// File: rtl/fpu_arith_resp_fmt.sv
// Response packing: selects and widens the arithmetic-unit result that
// matches the latched op code into the 80-bit response word.
// Ports: op (latched op code), result/int16/int32/fp32/fp64 (unit outputs),
//        data (packed 80-bit response).
module fpu_arith_resp_fmt
  import fpu_arith_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [79:0] result,
  input  logic [15:0] int16,
  input  logic [31:0] int32,
  input  logic [31:0] fp32,
  input  logic [63:0] fp64,
  output logic [79:0] data
);

  always_comb begin
    data = result;
    case (op)
      OP_FP_TO_INT16: data = {{64{int16[15]}}, int16};
      OP_FP_TO_INT32: data = {{48{int32[31]}}, int32};
      OP_FP_TO_FP32:  data = {48'd0, fp32};
      OP_FP_TO_FP64:  data = {16'd0, fp64};
      default:        data = result;
    endcase
  end

endmodule

// File: rtl/fpu_arith_sequencer.sv
// Command sequencer for an FP80 arithmetic unit. Accepts one command,
// pulses the unit enable, waits (bounded) for done and returns a response.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// ISSUE  | au_enable pulsed for one cycle, timeout timer loaded
// WAIT   | waiting for au_done or timer terminal count
// RESP   | rsp_valid high, payload held until rsp_ready
//
// Ports: clk/reset; cmd_* command handshake and operands; au_* unit control,
// latched operands and unit results; rsp_* response handshake and payload;
// sticky_flags/clear_sticky accumulated exceptions; busy (state != IDLE).
module fpu_arith_sequencer
  import fpu_arith_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [1:0]  cmd_rm,
  input  logic [79:0] cmd_a,
  input  logic [79:0] cmd_b,
  input  logic [63:0] cmd_raw,
  output logic [3:0]  au_operation,
  output logic        au_enable,
  output logic [1:0]  au_rounding_mode,
  output logic [79:0] au_operand_a,
  output logic [79:0] au_operand_b,
  output logic [15:0] au_int16_in,
  output logic [31:0] au_int32_in,
  output logic [31:0] au_fp32_in,
  output logic [63:0] au_fp64_in,
  input  logic        au_done,
  input  logic [79:0] au_result,
  input  logic [15:0] au_int16_out,
  input  logic [31:0] au_int32_out,
  input  logic [31:0] au_fp32_out,
  input  logic [63:0] au_fp64_out,
  input  logic [5:0]  au_flags,
  input  logic [3:0]  au_cc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [79:0] rsp_data,
  output logic [5:0]  rsp_flags,
  output logic [3:0]  rsp_cc,
  output logic        rsp_timeout,
  output logic [5:0]  sticky_flags,
  input  logic        clear_sticky,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Down-counter loaded at ISSUE; terminal count 0 marks the last WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [63:0]      raw_q;
  logic [79:0]      fmt_data;
  logic             capture;
  logic [5:0]       capture_flags;

  assign au_int16_in = raw_q[15:0];
  assign au_int32_in = raw_q[31:0];
  assign au_fp32_in  = raw_q[31:0];
  assign au_fp64_in  = raw_q;

  fpu_arith_resp_fmt u_resp_fmt (
    .op     (au_operation),
    .result (au_result),
    .int16  (au_int16_out),
    .int32  (au_int32_out),
    .fp32   (au_fp32_out),
    .fp64   (au_fp64_out),
    .data   (fmt_data)
  );

  // Any event that produces a response also feeds the sticky accumulator.
  always_comb begin
    capture       = 1'b0;
    capture_flags = '0;
    case (state)
      ST_IDLE: if (cmd_valid && !op_is_valid(cmd_op)) begin
        capture       = 1'b1;
        capture_flags = FLAGS_INVALID_ONLY;
      end
      ST_WAIT: if (au_done) begin
        capture       = 1'b1;
        capture_flags = au_flags;
      end else if (wait_cnt == '0) begin
        capture       = 1'b1;
        capture_flags = FLAGS_INVALID_ONLY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_flags <= '0;
    end else if (capture) begin
      sticky_flags <= clear_sticky ? capture_flags : (sticky_flags | capture_flags);
    end else if (clear_sticky) begin
      sticky_flags <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      raw_q            <= '0;
      au_operation     <= '0;
      au_rounding_mode <= '0;
      au_operand_a     <= '0;
      au_operand_b     <= '0;
      au_enable        <= 1'b0;
      cmd_ready        <= 1'b1;
      busy             <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_flags        <= '0;
      rsp_cc           <= '0;
      rsp_timeout      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          au_operation     <= cmd_op;
          au_rounding_mode <= cmd_rm;
          au_operand_a     <= cmd_a;
          au_operand_b     <= cmd_b;
          raw_q            <= cmd_raw;
          cmd_ready        <= 1'b0;
          busy             <= 1'b1;
          if (op_is_valid(cmd_op)) begin
            state     <= ST_ISSUE;
            au_enable <= 1'b1;
          end else begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_flags   <= FLAGS_INVALID_ONLY;
            rsp_cc      <= '0;
            rsp_timeout <= 1'b0;
          end
        end
        ST_ISSUE: begin
          au_enable <= 1'b0;
          wait_cnt  <= CNT_LOAD;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (au_done) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= fmt_data;
            rsp_flags   <= au_flags;
            rsp_cc      <= (au_operation <= OP_SUB) ? au_cc : 4'd0;
            rsp_timeout <= 1'b0;
          end else if (wait_cnt == '0) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_flags   <= FLAGS_INVALID_ONLY;
            rsp_cc      <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: if (rsp_ready) begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arith_sequencer.sv
// Self-checking bench for fpu_arith_sequencer (TIMEOUT_CYCLES = 8). The bench
// acts as the arithmetic unit stub; expected responses are queued when a
// command is driven and compared when the response handshake completes.
module tb_fpu_arith_sequencer;
  import fpu_arith_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [1:0]  cmd_rm = '0;
  logic [79:0] cmd_a = '0;
  logic [79:0] cmd_b = '0;
  logic [63:0] cmd_raw = '0;
  logic [3:0]  au_operation;
  logic        au_enable;
  logic [1:0]  au_rounding_mode;
  logic [79:0] au_operand_a, au_operand_b;
  logic [15:0] au_int16_in;
  logic [31:0] au_int32_in, au_fp32_in;
  logic [63:0] au_fp64_in;
  logic        au_done = 1'b0;
  logic [79:0] au_result = '0;
  logic [15:0] au_int16_out = '0;
  logic [31:0] au_int32_out = '0;
  logic [31:0] au_fp32_out = '0;
  logic [63:0] au_fp64_out = '0;
  logic [5:0]  au_flags = '0;
  logic [3:0]  au_cc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [79:0] rsp_data;
  logic [5:0]  rsp_flags;
  logic [3:0]  rsp_cc;
  logic        rsp_timeout;
  logic [5:0]  sticky_flags;
  logic        clear_sticky = 1'b0;
  logic        busy;

  typedef struct {
    logic [79:0] data;
    logic [5:0]  flags;
    logic [3:0]  cc;
    logic        timeout;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_count = 0;
  int   rsp_count = 0;

  fpu_arith_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rm(cmd_rm),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_raw(cmd_raw),
    .au_operation(au_operation), .au_enable(au_enable), .au_rounding_mode(au_rounding_mode),
    .au_operand_a(au_operand_a), .au_operand_b(au_operand_b),
    .au_int16_in(au_int16_in), .au_int32_in(au_int32_in),
    .au_fp32_in(au_fp32_in), .au_fp64_in(au_fp64_in),
    .au_done(au_done), .au_result(au_result),
    .au_int16_out(au_int16_out), .au_int32_out(au_int32_out),
    .au_fp32_out(au_fp32_out), .au_fp64_out(au_fp64_out),
    .au_flags(au_flags), .au_cc(au_cc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_cc(rsp_cc), .rsp_timeout(rsp_timeout),
    .sticky_flags(sticky_flags), .clear_sticky(clear_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (au_enable) en_count <= en_count + 1;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {79'd0, rsp_valid}, 80'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        rsp_count <= rsp_count + 1;
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_flags", {74'd0, rsp_flags}, {74'd0, e.flags});
        chk("rsp_cc", {76'd0, rsp_cc}, {76'd0, e.cc});
        chk("rsp_timeout", {79'd0, rsp_timeout}, {79'd0, e.timeout});
      end
    end
  end

  // Drives one command; returns at posedge+1 of the cycle after acceptance.
  task automatic send_cmd(input logic [3:0] op, input logic [1:0] rm, input logic [79:0] a,
                          input logic [79:0] b, input logic [63:0] raw, input logic clr);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      n++;
      tick();
    end
    chk("cmd_ready_wait", {79'd0, cmd_ready}, 80'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rm = rm; cmd_a = a; cmd_b = b; cmd_raw = raw;
    clear_sticky = clr;
    tick();
    cmd_valid = 1'b0;
    clear_sticky = 1'b0;
  endtask

  // Full command through the stub: done asserted after 'delay' extra WAIT cycles.
  task automatic do_op(input logic [3:0] op, input logic [1:0] rm, input logic [79:0] a,
                       input logic [79:0] b, input logic [63:0] raw, input int delay, input exp_t e);
    sb.push_back(e);
    send_cmd(op, rm, a, b, raw, 1'b0);
    chk("en_latency", {79'd0, au_enable}, 80'd1);
    chk("au_operation", {76'd0, au_operation}, {76'd0, op});
    chk("au_rm", {78'd0, au_rounding_mode}, {78'd0, rm});
    chk("au_operand_a", au_operand_a, a);
    chk("au_operand_b", au_operand_b, b);
    tick();
    chk("en_pulse", {79'd0, au_enable}, 80'd0);
    repeat (delay) tick();
    chk("op_stable", {76'd0, au_operation}, {76'd0, op});
    au_done = 1'b1;
    tick();
    au_done = 1'b0;
    chk("rsp_latency", {79'd0, rsp_valid}, 80'd1);
  endtask

  initial begin
    exp_t e;
    int n;
    int en_before;

    tick(3);
    chk("rst_cmd_ready", {79'd0, cmd_ready}, 80'd1);
    chk("rst_busy", {79'd0, busy}, 80'd0);
    chk("rst_rsp_valid", {79'd0, rsp_valid}, 80'd0);
    chk("rst_au_enable", {79'd0, au_enable}, 80'd0);
    chk("rst_sticky", {74'd0, sticky_flags}, 80'd0);
    chk("rst_rsp_data", rsp_data, 80'd0);
    chk("rst_operand_a", au_operand_a, 80'd0);
    reset = 1'b0;
    tick();

    // ADD 1.0 + 2.0 = 3.0, less condition code passed through
    au_result = 80'h4000C000000000000000; au_flags = 6'b000000; au_cc = 4'b1000;
    e = '{80'h4000C000000000000000, 6'b000000, 4'b1000, 1'b0};
    do_op(OP_ADD, 2'd0, 80'h3FFF8000000000000000, 80'h40008000000000000000, 64'd0, 0, e);
    chk("sticky_add", {74'd0, sticky_flags}, 80'd0);

    // SUB with extra latency, equal cc, inexact flag
    au_result = 80'h3FFE8000000000000001; au_flags = 6'b000001; au_cc = 4'b0100;
    e = '{80'h3FFE8000000000000001, 6'b000001, 4'b0100, 1'b0};
    do_op(OP_SUB, 2'd3, 80'h40008000000000000000, 80'h3FFF8000000000000001, 64'd0, 3, e);
    chk("sticky_sub", {74'd0, sticky_flags}, 80'd1);

    // DIV 1.0 / 0 -> zero_divide; cc from the unit is discarded for non-compare ops
    au_result = 80'h7FFF8000000000000000; au_flags = 6'b001000; au_cc = 4'b0001;
    e = '{80'h7FFF8000000000000000, 6'b001000, 4'b0000, 1'b0};
    do_op(OP_DIV, 2'd1, 80'h3FFF8000000000000000, 80'd0, 64'd0, 1, e);
    chk("sticky_div", {74'd0, sticky_flags}, {74'd0, 6'b001001});
    tick(2);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("sticky_clear", {74'd0, sticky_flags}, 80'd0);

    // FP_TO_INT16 of -2.0: sign-extended, raw slices latched
    au_result = 80'h0000000000000000ABCD; au_int16_out = 16'hFFFE; au_flags = '0; au_cc = '0;
    e = '{80'hFFFFFFFFFFFFFFFFFFFE, 6'b000000, 4'b0000, 1'b0};
    do_op(OP_FP_TO_INT16, 2'd0, 80'hC0008000000000000000, 80'd0, 64'h0123456789ABCDEF, 0, e);
    chk("au_int16_in", {64'd0, au_int16_in}, 80'hCDEF);
    chk("au_int32_in", {48'd0, au_int32_in}, 80'h89ABCDEF);
    chk("au_fp32_in", {48'd0, au_fp32_in}, 80'h89ABCDEF);
    chk("au_fp64_in", {16'd0, au_fp64_in}, 80'h0123456789ABCDEF);

    // FP_TO_INT32 negative, with inexact
    au_int32_out = 32'h80000001; au_flags = 6'b000001;
    e = '{80'hFFFFFFFFFFFF80000001, 6'b000001, 4'b0000, 1'b0};
    do_op(OP_FP_TO_INT32, 2'd2, 80'hC01DFFFFFFFE00000000, 80'd0, 64'd0, 2, e);

    // FP_TO_FP32 / FP_TO_FP64 zero-extended; INT16_TO_FP uses au_result
    au_fp32_out = 32'hC0000000; au_flags = '0;
    e = '{80'h000000000000C0000000, 6'b000000, 4'b0000, 1'b0};
    do_op(OP_FP_TO_FP32, 2'd0, 80'hC0008000000000000000, 80'd0, 64'd0, 0, e);
    au_fp64_out = 64'hC000000000000000;
    e = '{80'h0000C000000000000000, 6'b000000, 4'b0000, 1'b0};
    do_op(OP_FP_TO_FP64, 2'd0, 80'hC0008000000000000000, 80'd0, 64'd0, 1, e);
    au_result = 80'h4005FA00000000000000;
    e = '{80'h4005FA00000000000000, 6'b000000, 4'b0000, 1'b0};
    do_op(OP_INT16_TO_FP, 2'd0, 80'd0, 80'd0, 64'h000000000000007D, 0, e);
    chk("sticky_conv", {74'd0, sticky_flags}, 80'd1);

    // Timeout: the stub never answers; exactly 8 WAIT cycles
    e = '{80'd0, 6'b100000, 4'b0000, 1'b1};
    sb.push_back(e);
    send_cmd(OP_MUL, 2'd0, 80'h3FFF8000000000000000, 80'h3FFF8000000000000000, 64'd0, 1'b0);
    chk("to_en", {79'd0, au_enable}, 80'd1);
    tick();
    n = 0;
    while (!rsp_valid && n < 50) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", 80'(n), 80'd8);
    chk("to_sticky", {74'd0, sticky_flags}, {74'd0, 6'b100001});
    tick(2);

    // Invalid op 13 with simultaneous clear: response next cycle, held while not ready
    rsp_ready = 1'b0;
    en_before = en_count;
    e = '{80'd0, 6'b100000, 4'b0000, 1'b0};
    sb.push_back(e);
    send_cmd(4'd13, 2'd0, 80'h1234, 80'h5678, 64'd0, 1'b1);
    chk("inv_rsp_next", {79'd0, rsp_valid}, 80'd1);
    chk("inv_sticky_clr", {74'd0, sticky_flags}, {74'd0, 6'b100000});
    for (int i = 0; i < 5; i++) begin
      chk("inv_hold_valid", {79'd0, rsp_valid}, 80'd1);
      chk("inv_hold_data", rsp_data, 80'd0);
      chk("inv_hold_flags", {74'd0, rsp_flags}, {74'd0, 6'b100000});
      chk("inv_cmd_ready", {79'd0, cmd_ready}, 80'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick(2);
    chk("inv_no_enable", 80'(en_count), 80'(en_before));
    chk("inv_idle", {79'd0, busy}, 80'd0);

    // Reset during WAIT abandons the command; a late done is ignored
    send_cmd(OP_ADD, 2'd0, 80'h3FFF8000000000000000, 80'd0, 64'd0, 1'b0);
    tick(2);
    chk("mid_busy", {79'd0, busy}, 80'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    au_done = 1'b1; au_result = 80'h1; au_flags = 6'b111111;
    tick();
    au_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_rsp", {79'd0, rsp_valid}, 80'd0);
      chk("rst_mid_busy", {79'd0, busy}, 80'd0);
      tick();
    end
    chk("rst_mid_sticky", {74'd0, sticky_flags}, 80'd0);
    chk("rst_mid_ready", {79'd0, cmd_ready}, 80'd1);

    chk("sb_drained", 80'(sb.size()), 80'd0);
    chk("rsp_count", 80'(rsp_count), 80'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
